// File: rtl/segasys1_video_pkg.sv
// Shared constants and types for the System 1/2 video collision logic.
// Status-byte layout, filler bits and the sweep FSM state type.
package segasys1_video_pkg;

  localparam int unsigned STAT_SM   = 7;
  localparam int unsigned STAT_BUSY = 6;
  localparam int unsigned STAT_RD   = 0;

  localparam logic [4:0] STAT_FILL = 5'b11111;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_SWEEP
  } sweep_st_e;

endpackage

// File: rtl/segasys1_coll_prienc.sv
// Lowest-index-first priority encoder over the collision report ports.
// Gives the OR of all strobes and the address carried by the winning source.
module segasys1_coll_prienc #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned N_SRC  = 2
) (
  input  logic [N_SRC-1:0]        coll,
  input  logic [N_SRC*ADDR_W-1:0] coll_ad,
  output logic                    hit_any,
  output logic [ADDR_W-1:0]       hit_ad
);

  // Walk from the top down so the lowest active index is written last.
  always_comb begin
    hit_any = 1'b0;
    hit_ad  = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (coll[i]) begin
        hit_any = 1'b1;
        hit_ad  = coll_ad[i*ADDR_W +: ADDR_W];
      end
    end
  end

endmodule

// File: rtl/segasys1_collram_n.sv
// Configurable collision RAM: multi-port sets, CPU entry clear, swept clear-all,
// summary flag and first-hit capture, read back through a status byte.
module segasys1_collram_n
  import segasys1_video_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned N_SRC     = 2,
  parameter int unsigned SHOW_BUSY = 1
) (
  input  logic                    clk,
  input  logic                    RESET,
  input  logic [ADDR_W-1:0]       cpu_ad,
  input  logic                    cpu_wr_coll,
  input  logic                    cpu_wr_collclr,
  input  logic                    cpu_wr_clrall,
  output logic [7:0]              cpu_rd_coll,
  input  logic [N_SRC*ADDR_W-1:0] coll_ad,
  input  logic [N_SRC-1:0]        coll,
  output logic                    busy,
  output logic [ADDR_W-1:0]       first_ad,
  output logic                    first_vld
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  sweep_st_e         state_q, state_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic              sweep_clr_en;
  logic [DEPTH-1:0]  mem_q, mem_d, set_vec;
  logic              coll_rd_q, coll_sm_q, first_vld_q;
  logic [ADDR_W-1:0] first_ad_q;
  logic              hit_any;
  logic [ADDR_W-1:0] hit_ad;
  logic              sm_clr;

  segasys1_coll_prienc #(
    .ADDR_W (ADDR_W),
    .N_SRC  (N_SRC)
  ) u_prienc (
    .coll    (coll),
    .coll_ad (coll_ad),
    .hit_any (hit_any),
    .hit_ad  (hit_ad)
  );

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    sweep_clr_en = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cpu_wr_clrall) begin
          state_d = ST_SWEEP;
          ptr_d   = '0;
        end
      end
      ST_SWEEP: begin
        sweep_clr_en = 1'b1;
        if (cpu_wr_clrall) begin
          ptr_d = '0;
        end else if (ptr_q == (ADDR_W + 1)'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    set_vec = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (coll[i]) set_vec[coll_ad[i*ADDR_W +: ADDR_W]] = 1'b1;
    end
  end

  // Clears are applied after the set OR, so both clear sources beat any set.
  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    logic cpu_clr, swp_clr;
    assign cpu_clr  = cpu_wr_coll && (cpu_ad == ADDR_W'(g));
    assign swp_clr  = sweep_clr_en && (ptr_q[ADDR_W-1:0] == ADDR_W'(g));
    assign mem_d[g] = (mem_q[g] | set_vec[g]) & ~cpu_clr & ~swp_clr;
  end

  assign sm_clr = cpu_wr_collclr || cpu_wr_clrall;

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      mem_q       <= '0;
      coll_rd_q   <= 1'b0;
      coll_sm_q   <= 1'b0;
      first_vld_q <= 1'b0;
      first_ad_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      mem_q     <= mem_d;
      coll_rd_q <= mem_q[cpu_ad];
      if (sm_clr) begin
        coll_sm_q   <= 1'b0;
        first_vld_q <= 1'b0;
      end else if (hit_any) begin
        coll_sm_q <= 1'b1;
        if (!first_vld_q) begin
          first_vld_q <= 1'b1;
          first_ad_q  <= hit_ad;
        end
      end
    end
  end

  assign busy      = (state_q == ST_SWEEP);
  assign first_ad  = first_ad_q;
  assign first_vld = first_vld_q;

  always_comb begin
    cpu_rd_coll            = '0;
    cpu_rd_coll[STAT_SM]   = coll_sm_q;
    cpu_rd_coll[STAT_BUSY] = (SHOW_BUSY != 0) ? busy : 1'b1;
    cpu_rd_coll[5:1]       = STAT_FILL;
    cpu_rd_coll[STAT_RD]   = coll_rd_q;
  end

endmodule

// File: tb/tb_segasys1_collram_n.sv
// Directed bench for segasys1_collram_n: default 1024-entry build plus a
// 64-entry single-source build with busy hidden from the status byte.
module tb_segasys1_collram_n;

  logic        clk = 1'b0;
  logic        RESET;
  logic [9:0]  cpu_ad;
  logic        cpu_wr_coll, cpu_wr_collclr, cpu_wr_clrall;
  logic [7:0]  cpu_rd_coll;
  logic [19:0] coll_ad;
  logic [1:0]  coll;
  logic        busy;
  logic [9:0]  first_ad;
  logic        first_vld;

  logic [5:0]  b_ad;
  logic        b_wr_coll, b_wr_collclr, b_wr_clrall;
  logic [7:0]  b_rd;
  logic [5:0]  b_coll_ad;
  logic        b_coll;
  logic        b_busy;
  logic [5:0]  b_first_ad;
  logic        b_first_vld;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  segasys1_collram_n #(
    .ADDR_W    (10),
    .N_SRC     (2),
    .SHOW_BUSY (1)
  ) dut_a (
    .clk            (clk),
    .RESET          (RESET),
    .cpu_ad         (cpu_ad),
    .cpu_wr_coll    (cpu_wr_coll),
    .cpu_wr_collclr (cpu_wr_collclr),
    .cpu_wr_clrall  (cpu_wr_clrall),
    .cpu_rd_coll    (cpu_rd_coll),
    .coll_ad        (coll_ad),
    .coll           (coll),
    .busy           (busy),
    .first_ad       (first_ad),
    .first_vld      (first_vld)
  );

  segasys1_collram_n #(
    .ADDR_W    (6),
    .N_SRC     (1),
    .SHOW_BUSY (0)
  ) dut_b (
    .clk            (clk),
    .RESET          (RESET),
    .cpu_ad         (b_ad),
    .cpu_wr_coll    (b_wr_coll),
    .cpu_wr_collclr (b_wr_collclr),
    .cpu_wr_clrall  (b_wr_clrall),
    .cpu_rd_coll    (b_rd),
    .coll_ad        (b_coll_ad),
    .coll           (b_coll),
    .busy           (b_busy),
    .first_ad       (b_first_ad),
    .first_vld      (b_first_vld)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic rd(input logic [9:0] a);
    cpu_ad = a;
    tick();
  endtask

  initial begin
    int bad;
    int cnt;
    int cyc;
    int last_busy;

    RESET = 1'b1;
    cpu_ad = '0; cpu_wr_coll = 0; cpu_wr_collclr = 0; cpu_wr_clrall = 0;
    coll_ad = '0; coll = '0;
    b_ad = '0; b_wr_coll = 0; b_wr_collclr = 0; b_wr_clrall = 0;
    b_coll_ad = '0; b_coll = 0;
    tick();
    tick();
    RESET = 1'b0;

    chk("a_reset_status", cpu_rd_coll, 8'h3E);
    chk("a_reset_busy", busy, 0);
    chk("a_reset_first_vld", first_vld, 0);
    chk("a_reset_first_ad", first_ad, 0);
    chk("b_reset_status", b_rd, 8'h7E);

    bad = 0;
    for (int a = 0; a < 1024; a++) begin
      rd(10'(a));
      if (cpu_rd_coll !== 8'h3E) bad++;
    end
    chk("a_reset_all_entries", bad, 0);

    // Both sources hit entry 5 in the same cycle.
    coll = 2'b11; coll_ad = {10'd5, 10'd5};
    tick();
    coll = 2'b00;
    chk("a_first_ad_5", first_ad, 5);
    chk("a_first_vld", first_vld, 1);
    chk("a_sm_set", cpu_rd_coll[7], 1);
    rd(10'd5);
    chk("a_entry5_set", cpu_rd_coll[0], 1);

    coll = 2'b10; coll_ad = {10'd9, 10'd0};
    tick();
    coll = 2'b00;
    chk("a_first_ad_held", first_ad, 5);
    rd(10'd9);
    chk("a_entry9_set", cpu_rd_coll[0], 1);
    rd(10'd0);
    chk("a_entry0_unset", cpu_rd_coll[0], 0);

    // CPU clear beats a same-cycle set.
    cpu_wr_coll = 1; cpu_ad = 10'd12; coll = 2'b01; coll_ad = {10'd0, 10'd12};
    tick();
    cpu_wr_coll = 0; coll = 2'b00;
    rd(10'd12);
    chk("a_cpu_clr_beats_set", cpu_rd_coll[0], 0);

    cpu_wr_coll = 1; cpu_ad = 10'd5;
    tick();
    cpu_wr_coll = 0;
    rd(10'd5);
    chk("a_cpu_clr_entry5", cpu_rd_coll[0], 0);

    cpu_wr_collclr = 1; coll = 2'b11; coll_ad = {10'd20, 10'd30};
    tick();
    cpu_wr_collclr = 0; coll = 2'b00;
    chk("a_collclr_sm", cpu_rd_coll[7], 0);
    chk("a_collclr_vld", first_vld, 0);

    coll = 2'b11; coll_ad = {10'd40, 10'd41};
    tick();
    coll = 2'b00;
    chk("a_first_lowest_src", first_ad, 41);
    chk("a_first_vld_again", first_vld, 1);

    // Sweep 1: busy length and set races against the pointer.
    cpu_wr_clrall = 1;
    tick();
    cpu_wr_clrall = 0;
    cyc = 1;
    chk("a_sweep_busy", busy, 1);
    chk("a_sweep_status", cpu_rd_coll, 8'h7E);
    chk("a_sweep_vld_clr", first_vld, 0);
    cnt = 0;
    while (busy && cyc < 3000) begin
      coll = 2'b00;
      if (cyc == 100) begin coll = 2'b11; coll_ad = {10'd900, 10'd3}; end
      if (cyc == 200) begin coll = 2'b01; coll_ad = {10'd0, 10'd199}; end
      cnt++;
      tick();
      cyc++;
    end
    coll = 2'b00;
    chk("a_busy_1024", cnt, 1024);
    chk("a_first_in_sweep", first_ad, 3);
    rd(10'd3);
    chk("a_behind_ptr_persists", cpu_rd_coll[0], 1);
    rd(10'd900);
    chk("a_ahead_ptr_cleared", cpu_rd_coll[0], 0);
    rd(10'd199);
    chk("a_at_ptr_cleared", cpu_rd_coll[0], 0);
    rd(10'd41);
    chk("a_old_entry_swept", cpu_rd_coll[0], 0);

    // Sweep 2: restart at T+500.
    cpu_wr_clrall = 1;
    tick();
    cpu_wr_clrall = 0;
    cyc = 1;
    last_busy = 0;
    while (busy && cyc < 3000) begin
      coll = 2'b00;
      cpu_wr_clrall = 0;
      if (cyc == 401) chk("a_sm_in_sweep", cpu_rd_coll[7], 1);
      if (cyc == 501) begin
        chk("a_restart_sm", cpu_rd_coll[7], 0);
        chk("a_restart_vld", first_vld, 0);
      end
      if (cyc == 400) begin coll = 2'b01; coll_ad = {10'd0, 10'd2}; end
      if (cyc == 500) cpu_wr_clrall = 1;
      last_busy = cyc;
      tick();
      cyc++;
    end
    cpu_wr_clrall = 0;
    chk("a_restart_busy_end", last_busy, 1524);
    rd(10'd2);
    chk("a_restart_reclears", cpu_rd_coll[0], 0);

    // Sweep 3: reset aborts mid-sweep.
    coll = 2'b01; coll_ad = {10'd0, 10'd1000};
    tick();
    coll = 2'b00;
    cpu_wr_clrall = 1;
    tick();
    cpu_wr_clrall = 0;
    for (int c = 1; c < 700; c++) begin
      coll = 2'b00;
      if (c == 650) begin coll = 2'b01; coll_ad = {10'd0, 10'd5}; end
      tick();
    end
    coll = 2'b00;
    RESET = 1;
    tick();
    RESET = 0;
    chk("a_reset_abort_busy", busy, 0);
    chk("a_reset_abort_status", cpu_rd_coll, 8'h3E);
    bad = 0;
    for (int a = 0; a < 1024; a++) begin
      rd(10'(a));
      if (cpu_rd_coll[0] !== 1'b0) bad++;
    end
    chk("a_reset_abort_entries", bad, 0);

    // 64-entry build, single source, busy hidden.
    b_coll = 1; b_coll_ad = 6'd63;
    tick();
    b_coll = 0;
    chk("b_first_ad", b_first_ad, 63);
    b_ad = 6'd63;
    tick();
    chk("b_entry63_set", b_rd, 8'hFF);
    b_wr_coll = 1;
    tick();
    b_wr_coll = 0;
    tick();
    chk("b_entry63_clr", b_rd[0], 0);
    b_coll = 1; b_coll_ad = 6'd10;
    tick();
    b_coll = 0;
    b_wr_clrall = 1;
    tick();
    b_wr_clrall = 0;
    cnt = 0;
    bad = 0;
    while (b_busy && cnt < 200) begin
      if (b_rd[6] !== 1'b1) bad++;
      cnt++;
      tick();
    end
    chk("b_busy_64", cnt, 64);
    chk("b_bit6_stuck_high", bad, 0);
    b_ad = 6'd10;
    tick();
    chk("b_swept_entry10", b_rd, 8'h7E);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/segasys1_collram_n.md
# segasys1_collram_n

Parametrised collision RAM for the System 1/2 video path. It replaces the fixed 64-entry mixer and 1024-entry sprite collision RAMs with one configurable block. It accepts up to N_SRC hardware collision reports per clock and adds a swept clear-all command with a busy flag. It also captures the first collision address after each summary clear. The block sits between the mixer/sprite engines (set side) and the CPU read-data selector (read/clear side).

## Interface
Parameters:
- ADDR_W, default 10: entry address width; DEPTH = 2**ADDR_W (6 selects the mixer configuration).
- N_SRC, default 2: number of independent collision report ports per clock (1..4).
- SHOW_BUSY, default 1: 1 puts busy on status bit 6; 0 reads that bit as 1.

Ports (clock and reset first):
- clk  in  1  video clock; the block has one clock; all logic on the rising edge.
- RESET  in  1  reset, synchronous and active-high.
- cpu_ad  in  ADDR_W  CPU entry address.
- cpu_wr_coll  in  1  write strobe; clears entry cpu_ad.
- cpu_wr_collclr  in  1  write strobe; clears the summary flag and first-hit capture.
- cpu_wr_clrall  in  1  pulse; starts the swept clear of all entries.
- cpu_rd_coll  out  8  status byte {coll_sm, bit6, 5'b11111, coll_rd}.
- coll_ad  in  N_SRC*ADDR_W  per-source entry address; source i occupies bits [i*ADDR_W +: ADDR_W].
- coll  in  N_SRC  per-source collision strobe.
- busy  out  1  a sweep is in progress.
- first_ad  out  ADDR_W  address of the first collision after the last clear.
- first_vld  out  1  first_ad is valid.

## Operation
- Storage is a DEPTH-bit flop vector. Per clock, several sets are allowed and at most two clears (one CPU clear, one sweep clear).
- Set: for each i with coll[i]=1, entry coll_ad[i] is set to 1. Duplicate addresses set the entry once.
- CPU clear: cpu_wr_coll clears entry cpu_ad. A CPU clear beats any set to the same address in the same cycle.
- Read: coll_rd is the registered value of entry cpu_ad, so the value sampled is the entry before that edge's updates.
- Summary flag coll_sm: set when any coll[i]=1. cpu_wr_collclr or the sweep start clears it, and the clear wins over a simultaneous set.
- First-hit capture: when first_vld=0 and some coll[i]=1, first_ad takes the lowest-index active source's address and first_vld goes to 1. The capture holds until cpu_wr_collclr or the sweep start, each of which clears first_vld and wins over a simultaneous hit.
- Sweep FSM, state IDLE:
  - cpu_wr_clrall moves to SWEEP with ptr=0.
  - On the same edge, coll_sm and first_vld are cleared.
- Sweep FSM, state SWEEP:
  - Each cycle clears entry ptr, then ptr increments.
  - After ptr=DEPTH-1 is cleared, the FSM returns to IDLE.
  - A cpu_wr_clrall pulse during SWEEP restarts the sweep at ptr=0 and clears coll_sm and first_vld again.
- Priority at the entry equal to ptr: the sweep clear beats any set.
- Sets to entries at or behind ptr persist; sets ahead of ptr are cleared when the pointer reaches them.
- CPU entry clears and reads operate normally during SWEEP.
- bit6 of cpu_rd_coll equals busy when SHOW_BUSY=1, and reads 1 otherwise.

## Timing
- Reset values:
  - All entries 0; coll_rd, coll_sm, first_vld = 0; first_ad = 0.
  - busy = 0, state IDLE, ptr = 0.
  - cpu_rd_coll = {0, SHOW_BUSY?0:1, 5'b11111, 0}.
- A RESET that arrives mid-sweep aborts the sweep; the next cycle is IDLE with all entries 0.
- Read latency: 1 clock from cpu_ad to coll_rd. coll_sm, first_*, and busy are registered outputs.
- Sweep timing for a cpu_wr_clrall pulse in cycle T:
  - busy = 1 from T+1 through T+DEPTH.
  - The edge ending cycle T+k clears entry k-1.
  - busy = 0 at T+DEPTH+1.
- A set lands on the edge following its strobe; it is visible through coll_rd two cycles after the strobe, provided cpu_ad is already pointing at the entry.
- ptr is ADDR_W+1 bits wide so that termination at DEPTH-1 is detected without wrap ambiguity.

## Structure
- Shared package segasys1_video_pkg holds:
  - Status-byte bit positions: SM=7, BUSY=6, RD=0.
  - The constant filler 5'b11111.
  - The FSM state enum {ST_IDLE, ST_SWEEP}.
- One sub-module, segasys1_coll_prienc: N_SRC-input lowest-index-first priority encoder. It outputs hit_any, the winning source's address, and the OR of the strobes, and is used by the summary and first-hit logic.
- The per-entry next-state logic is a generate loop over DEPTH: set vector OR, then CPU clear mask, then sweep clear mask.

## Test plan
- Reset then read all entries → every coll_rd = 0 and status byte = 8'h3E (SHOW_BUSY=1).
- coll=2'b11 with coll_ad = {10'd5, 10'd5} → entry 5 set, coll_sm = 1, first_ad = 5, first_vld = 1. A later hit at 9 leaves first_ad = 5.
- cpu_wr_coll at 12 while coll[0] targets 12 in the same cycle → entry 12 = 0. Likewise cpu_wr_collclr with a simultaneous coll → coll_sm = 0, first_vld = 0.
- cpu_wr_clrall with ADDR_W=10:
  - busy is high for exactly 1024 cycles.
  - A set at entry 3 during cycle T+100 persists.
  - A set at entry 900 during cycle T+100 is cleared.
  - A set at ptr in the same cycle is cleared.
- Second cpu_wr_clrall at T+500 → busy extends to T+1524. RESET asserted at T+700 → busy = 0 and all entries read 0 the next cycle.
- ADDR_W=6, N_SRC=1, SHOW_BUSY=0 → 64-entry behaviour matches the legacy mixer collision RAM, and bit6 always reads 1.
